// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel types, frame geometry and colour expansion for scanout
package video_pkg;

   localparam int VIDEO_WIDTH  = 640;
   localparam int VIDEO_HEIGHT = 400;

   typedef logic [15:0] rgb565_t;
   typedef logic [23:0] rgb888_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } fetch_state_t;

   // Widen 565 to 888 by replicating each channel's MSBs into the new LSBs,
   // so full-scale inputs map to full-scale outputs.
   function automatic rgb888_t rgb565_to_888(input rgb565_t p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

endpackage

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - dual-bank 1W1R line RAM with registered read
module video_line_buffer
   import video_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic          i_clock,
   input  logic          i_wr_en,
   input  logic          i_wr_bank,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [31:0]   i_wr_data,
   input  logic          i_rd_bank,
   input  logic [AW-1:0] i_rd_addr,
   output logic [31:0]   o_rd_data
);

   // Bank selects the top address bit; no reset so the array maps onto block RAM.
   logic [31:0] mem_q [0:(2 << AW) - 1];
   logic [31:0] rd_data_q;

   // Synchronous write port and registered read port.
   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         mem_q[{i_wr_bank, i_wr_addr}] <= i_wr_data;
      end
      rd_data_q <= mem_q[{i_rd_bank, i_rd_addr}];
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - scanline prefetch into ping-pong buffer and RGB888 pixel output
module video_scanout
   import video_pkg::*;
#(
   parameter int          WIDTH        = VIDEO_WIDTH,
   parameter int          HEIGHT       = VIDEO_HEIGHT,
   parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_data_enable,
   input  logic [9:0]  i_pos_x,
   input  logic [9:0]  i_pos_y,
   input  logic [31:0] i_base,
   output logic        o_bus_request,
   output logic [31:0] o_bus_address,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_data_enable,
   output logic [23:0] o_rgb,
   output logic        o_underrun
);

   localparam logic [8:0]  LAST_WORD  = 9'(WIDTH / 2 - 1);
   localparam logic [31:0] LINE_BYTES = 32'(WIDTH * 2);
   localparam logic [9:0]  LAST_Y     = 10'(HEIGHT - 1);

   fetch_state_t state_q, state_d;
   logic [31:0]  line_addr_q, line_addr_d;
   logic [8:0]   word_q, word_d;
   logic         bank_q, bank_d;
   logic [1:0]   ready_q, ready_d;
   logic         underrun_q, underrun_d;
   logic         vsync_prev_q, vsync_prev_d;
   logic         de_prev_q, de_prev_d;
   logic [1:0]   hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic         x0_q, x0_d;
   logic         ok_q, ok_d;
   logic [23:0]  rgb_q, rgb_d;

   logic         frame_start, line_trig, wr_en, pix_underrun;
   logic [31:0]  rd_data;
   rgb565_t      half;

   assign frame_start = vsync_prev_q & ~i_vsync;
   // The last line has no successor to prefetch, so its enable edge is ignored.
   assign line_trig   = ~de_prev_q & i_data_enable & (i_pos_y < LAST_Y);

   video_line_buffer #(.AW(9)) u_line_buffer (
      .i_clock   (i_clock),
      .i_wr_en   (wr_en),
      .i_wr_bank (bank_q),
      .i_wr_addr (word_q),
      .i_wr_data (i_bus_rdata),
      .i_rd_bank (i_pos_y[0]),
      .i_rd_addr (i_pos_x[9:1]),
      .o_rd_data (rd_data)
   );

   // Fetch FSM: burst one line into its bank; a new trigger always wins over an unfinished fetch.
   always_comb begin
      state_d     = state_q;
      line_addr_d = line_addr_q;
      word_d      = word_q;
      bank_d      = bank_q;
      ready_d     = ready_q;
      underrun_d  = underrun_q | pix_underrun;
      wr_en       = 1'b0;
      case (state_q)
         S_REQ: begin
            if (i_bus_ready) begin
               wr_en  = 1'b1;
               word_d = word_q + 9'd1;
               if (word_q == LAST_WORD) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            ready_d[bank_q] = 1'b1;
            line_addr_d     = line_addr_q + LINE_BYTES;
            state_d         = S_IDLE;
         end
         default: ;
      endcase
      if (frame_start) begin
         line_addr_d = i_base;
         ready_d     = 2'b00;
         bank_d      = 1'b0;
         word_d      = 9'd0;
         state_d     = S_REQ;
      end else if (line_trig) begin
         // An aborted line still advances the address so it tracks the line index.
         if (state_q == S_REQ) begin
            underrun_d  = 1'b1;
            line_addr_d = line_addr_q + LINE_BYTES;
         end
         bank_d          = ~i_pos_y[0];
         ready_d[bank_d] = 1'b0;
         word_d          = 9'd0;
         state_d         = S_REQ;
      end
   end

   // Pixel path: stage 1 is the RAM read, stage 2 selects the half-word and expands colour.
   always_comb begin
      vsync_prev_d = i_vsync;
      de_prev_d    = i_data_enable;
      hs_d         = {hs_q[0], i_hsync};
      vs_d         = {vs_q[0], i_vsync};
      de_d         = {de_q[0], i_data_enable};
      x0_d         = i_pos_x[0];
      ok_d         = ready_q[i_pos_y[0]] & i_data_enable;
      half         = x0_q ? rd_data[31:16] : rd_data[15:0];
      pix_underrun = de_q[0] & ~ok_q;
      rgb_d        = 24'd0;
      if (de_q[0]) begin
         rgb_d = ok_q ? rgb565_to_888(half) : UNDERRUN_RGB;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         line_addr_q  <= 32'd0;
         word_q       <= 9'd0;
         bank_q       <= 1'b0;
         ready_q      <= 2'b00;
         underrun_q   <= 1'b0;
         vsync_prev_q <= 1'b0;
         de_prev_q    <= 1'b0;
         hs_q         <= 2'b00;
         vs_q         <= 2'b00;
         de_q         <= 2'b00;
         x0_q         <= 1'b0;
         ok_q         <= 1'b0;
         rgb_q        <= 24'd0;
      end else begin
         state_q      <= state_d;
         line_addr_q  <= line_addr_d;
         word_q       <= word_d;
         bank_q       <= bank_d;
         ready_q      <= ready_d;
         underrun_q   <= underrun_d;
         vsync_prev_q <= vsync_prev_d;
         de_prev_q    <= de_prev_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         de_q         <= de_d;
         x0_q         <= x0_d;
         ok_q         <= ok_d;
         rgb_q        <= rgb_d;
      end
   end

   assign o_bus_request = (state_q == S_REQ);
   assign o_bus_address = line_addr_q + {21'd0, word_q, 2'b00};
   assign o_hsync       = hs_q[1];
   assign o_vsync       = vs_q[1];
   assign o_data_enable = de_q[1];
   assign o_rgb         = rgb_q;
   assign o_underrun    = underrun_q;

endmodule
